shift_unit: RTL and testbench



---
 rtl/shift_unit_pkg.sv | 22 ++
 rtl/shift_step.sv | 54 +++++
 rtl/shift_unit.sv | 139 +++++++++++++
 tb/tb_shift_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_unit_pkg.sv
// Shared constants and types for the multi-cycle shift/rotate unit.
// Optional carry output is enabled with SHIFT_UNIT_CARRY_EN.
package shift_unit_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_SHL0 = 3'b000;
    localparam logic [MODE_W-1:0] MODE_SHL1 = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHR0 = 3'b010;
    localparam logic [MODE_W-1:0] MODE_SHR1 = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ASR  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_PASS = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Single-position shift/rotate step, purely combinational.
// out_bit is the bit leaving the word; 0 for pass.
module shift_step
    import shift_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  value,
    input  logic [MODE_W-1:0] mode,
    input  logic              asr_fill,
    output logic [WIDTH-1:0]  next_value,
    output logic              out_bit
);

    always_comb begin
        next_value = value;
        out_bit    = 1'b0;
        unique case (mode)
            MODE_SHL0: begin
                next_value = {value[WIDTH-2:0], 1'b0};
                out_bit    = value[WIDTH-1];
            end
            MODE_SHL1: begin
                next_value = {value[WIDTH-2:0], 1'b1};
                out_bit    = value[WIDTH-1];
            end
            MODE_SHR0: begin
                next_value = {1'b0, value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            MODE_SHR1: begin
                next_value = {1'b1, value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            MODE_ASR: begin
                next_value = {asr_fill, value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            MODE_ROR: begin
                next_value = {value[0], value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            MODE_ROL: begin
                next_value = {value[WIDTH-2:0], value[WIDTH-1]};
                out_bit    = value[WIDTH-1];
            end
            default: begin
                next_value = value;
                out_bit    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shift/rotate engine: one step per clock, start/busy/done.
// Define SHIFT_UNIT_CARRY_EN to add carry output c.
module shift_unit
    import shift_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  a,
    input  logic [MODE_W-1:0] mode,
    input  logic [AMT_W-1:0]  amt,
    output logic [WIDTH-1:0]  r,
`ifdef SHIFT_UNIT_CARRY_EN
    output logic              c,
`endif
    output logic              busy,
    output logic              done
);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    work_q, work_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [AMT_W-1:0]    cnt_q, cnt_d;
    logic                fill_q, fill_d;
    logic [WIDTH-1:0]    r_q, r_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [WIDTH-1:0]    step_value;
`ifdef SHIFT_UNIT_CARRY_EN
    logic                c_q, c_d;
    logic                step_carry;
`else
    logic                step_carry_unused;
`endif

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .value      (work_q),
        .mode       (mode_q),
        .asr_fill   (fill_q),
        .next_value (step_value),
`ifdef SHIFT_UNIT_CARRY_EN
        .out_bit    (step_carry)
`else
        .out_bit    (step_carry_unused)
`endif
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        r_d     = r_q;
`ifdef SHIFT_UNIT_CARRY_EN
        c_d     = c_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    work_d = a;
                    mode_d = mode;
                    cnt_d  = amt;
                    fill_d = a[WIDTH-1];
                    if (amt != '0) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                        r_d     = a;
`ifdef SHIFT_UNIT_CARRY_EN
                        c_d     = 1'b0;
`endif
                    end
                end
            end
            SHIFT: begin
                work_d = step_value;
                cnt_d  = cnt_q - 1'b1;
                // Last step publishes straight from the step network.
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                    r_d     = step_value;
`ifdef SHIFT_UNIT_CARRY_EN
                    c_d     = step_carry;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            mode_q  <= MODE_SHL0;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SHIFT_UNIT_CARRY_EN
            c_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SHIFT_UNIT_CARRY_EN
            c_q     <= c_d;
`endif
        end
    end

    assign r    = r_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef SHIFT_UNIT_CARRY_EN
    assign c    = c_q;
`endif

endmodule

// File: tb/tb_shift_unit.sv
// Directed-vector bench for shift_unit (WIDTH=8).
// Checks carry output too when SHIFT_UNIT_CARRY_EN is defined.
module tb_shift_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [2:0] mode;
    logic [3:0] amt;
    logic [7:0] r;
    logic       busy;
    logic       done;
`ifdef SHIFT_UNIT_CARRY_EN
    logic       c;
`endif

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] a;
        logic [2:0] mode;
        logic [3:0] amt;
        logic [7:0] exp_r;
        logic       exp_c;
    } vec_t;

    vec_t tbl[12];

    always #5 clk = ~clk;

    shift_unit #(
        .WIDTH(8),
        .AMT_W(4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .mode  (mode),
        .amt   (amt),
        .r     (r),
`ifdef SHIFT_UNIT_CARRY_EN
        .c     (c),
`endif
        .busy  (busy),
        .done  (done)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one op, then check accept, latency, result and done pulse.
    task automatic run_op(input string nm, input logic [7:0] va,
                          input logic [2:0] vm, input logic [3:0] vamt,
                          input logic [7:0] er, input logic ec);
        int         n;
        logic [7:0] prev;
        bit         early;
        @(negedge clk);
        prev  = r;
        early = 1'b0;
        a     = va;
        mode  = vm;
        amt   = vamt;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({nm, " busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 40) begin
            if (r !== prev) early = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, " latency"}, 32'(n), 32'(vamt));
        chk({nm, " r"}, 32'(r), 32'(er));
`ifdef SHIFT_UNIT_CARRY_EN
        chk({nm, " c"}, 32'(c), 32'(ec));
`endif
        chk({nm, " r_early"}, 32'(early), 32'd0);
        @(posedge clk);
        #1;
        chk({nm, " done_busy_drop"}, 32'({done, busy}), 32'd0);
    endtask

    initial begin
        logic [7:0] bb_a[4];
        logic [7:0] bb_r[4];
        logic [7:0] cur_r;
        int         nd;
        int         last;
        bit         stable;
        bit         seen;

        tbl[0]  = '{8'h81, 3'b001, 4'd3,  8'h0F, 1'b0};
        tbl[1]  = '{8'h90, 3'b100, 4'd2,  8'hE4, 1'b0};
        tbl[2]  = '{8'h81, 3'b110, 4'd9,  8'h03, 1'b1};
        tbl[3]  = '{8'h81, 3'b101, 4'd1,  8'hC0, 1'b1};
        tbl[4]  = '{8'hFF, 3'b010, 4'd12, 8'h00, 1'b0};
        tbl[5]  = '{8'h5A, 3'b000, 4'd0,  8'h5A, 1'b0};
        tbl[6]  = '{8'h5A, 3'b111, 4'd5,  8'h5A, 1'b0};
        tbl[7]  = '{8'h0F, 3'b011, 4'd4,  8'hF0, 1'b1};
        tbl[8]  = '{8'hA5, 3'b000, 4'd8,  8'h00, 1'b1};
        tbl[9]  = '{8'h80, 3'b100, 4'd15, 8'hFF, 1'b1};
        tbl[10] = '{8'h96, 3'b101, 4'd8,  8'h96, 1'b1};
        tbl[11] = '{8'hC3, 3'b110, 4'd1,  8'h87, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        mode  = '0;
        amt   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset r", 32'(r), 32'd0);
        chk("reset busy_done", 32'({busy, done}), 32'd0);
`ifdef SHIFT_UNIT_CARRY_EN
        chk("reset c", 32'(c), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("v%0d", i), tbl[i].a, tbl[i].mode,
                   tbl[i].amt, tbl[i].exp_r, tbl[i].exp_c);
        end

        // Reset in the middle of a long rotate.
        @(negedge clk);
        a     = 8'h81;
        mode  = 3'b110;
        amt   = 4'd10;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst busy_done", 32'({busy, done}), 32'd0);
        chk("midrst r", 32'(r), 32'd0);
`ifdef SHIFT_UNIT_CARRY_EN
        chk("midrst c", 32'(c), 32'd0);
`endif
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        chk("midrst no_done", 32'(seen), 32'd0);
        run_op("post_rst", 8'h81, 3'b110, 4'd10, 8'h06, 1'b0);

        // start held high: accepts every amt+2 cycles.
        bb_a[0] = 8'h01; bb_r[0] = 8'h04;
        bb_a[1] = 8'h03; bb_r[1] = 8'h0C;
        bb_a[2] = 8'h11; bb_r[2] = 8'h44;
        bb_a[3] = 8'h40; bb_r[3] = 8'h00;
        cur_r  = 8'h06;
        nd     = 0;
        last   = 0;
        stable = 1'b1;
        @(negedge clk);
        a     = bb_a[0];
        mode  = 3'b000;
        amt   = 4'd2;
        start = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(posedge clk);
            #1;
            if (done && nd < 4) begin
                chk($sformatf("b2b%0d r", nd), 32'(r), 32'(bb_r[nd]));
                if (nd == 0)
                    chk("b2b first", 32'(cyc), 32'd2);
                else
                    chk($sformatf("b2b%0d gap", nd), 32'(cyc - last), 32'd4);
                cur_r = bb_r[nd];
                last  = cyc;
                nd++;
                if (nd < 4) a = bb_a[nd];
            end else if (r !== cur_r) begin
                stable = 1'b0;
            end
        end
        start = 1'b0;
        chk("b2b count", 32'(nd), 32'd4);
        chk("b2b stable", 32'(stable), 32'd1);
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
